// File: rtl/mic_capture_writer_if.sv
// Sample-pair stream between the microphone front end and the capture writer.
interface mic_capture_writer_if #(
  parameter int unsigned DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_ch0;
  logic [DATA_W-1:0] s_ch1;

  modport master (output s_valid, output s_ch0, output s_ch1, input s_ready);
  modport slave  (input s_valid, input s_ch0, input s_ch1, output s_ready);
endinterface

// File: rtl/mic_capture_writer.sv
// Fills both mic sample RAMs (port A) with one 1024-pair frame, then freezes them until frame_ack.
// Optional CAPTURE_OVERRUN_EN: accept-and-drop pairs while holding, counted in overrun_cnt.
module mic_capture_writer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 10,
  parameter bit          AUTO_REARM = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  mic_capture_writer_if.slave  s_if,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_din0,
  output logic [DATA_W-1:0]    mem_din1,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic [7:0]           frame_cnt,
  output logic [15:0]          overrun_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_HOLD} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din0;
  logic [DATA_W-1:0]   r_din1;
  logic                r_fv;
  logic [7:0]          r_fcnt;
  logic                w_ready;
  logic                w_hs;
  logic                w_fill_hs;
  logic                w_last;
  logic                w_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_FILL;
      ST_FILL: if (w_last) w_next = ST_HOLD;
      ST_HOLD: if (w_ack) w_next = AUTO_REARM ? ST_FILL : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // s_ready depends only on the state register, never on s_valid.
  always_comb begin
    w_ready = (r_state == ST_FILL);
`ifdef CAPTURE_OVERRUN_EN
    if (r_state == ST_HOLD) w_ready = 1'b1;
`endif
    w_hs      = s_if.s_valid && w_ready;
    w_fill_hs = w_hs && (r_state == ST_FILL);
    w_last    = w_fill_hs && (r_wr_ptr == '1);
    w_ack     = (r_state == ST_HOLD) && r_fv && frame_ack;
  end

  assign s_if.s_ready = w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_din0   <= '0;
      r_din1   <= '0;
    end else begin
      r_we <= w_fill_hs;
      if (r_state == ST_IDLE && start) begin
        r_wr_ptr <= '0;
      end else if (w_fill_hs) begin
        r_addr   <= r_wr_ptr;
        r_din0   <= s_if.s_ch0;
        r_din1   <= s_if.s_ch1;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  // frame_valid lags HOLD entry by one cycle so the last write has landed first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fv   <= 1'b0;
      r_fcnt <= '0;
    end else if (w_ack) begin
      r_fv   <= 1'b0;
      r_fcnt <= r_fcnt + 8'd1;
    end else if (r_state == ST_HOLD) begin
      r_fv   <= 1'b1;
    end
  end

`ifdef CAPTURE_OVERRUN_EN
  logic [15:0] r_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovr <= '0;
    else if (w_hs && (r_state == ST_HOLD) && (r_ovr != '1)) r_ovr <= r_ovr + 16'd1;
  end

  assign overrun_cnt = r_ovr;
`else
  assign overrun_cnt = '0;
`endif

  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_din0    = r_din0;
  assign mem_din1    = r_din1;
  assign frame_valid = r_fv;
  assign frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_mic_capture_writer.sv
// Bench for mic_capture_writer: DUT 0 auto-rearms, DUT 1 returns to IDLE after each ack.
module tb_mic_capture_writer;

`ifdef CAPTURE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  localparam int unsigned LOGN = 8192;

  logic clk;
  logic rst_n;
  logic [1:0]       start, ack, v;
  logic [1:0][15:0] c0, c1;
  logic [1:0]       rdy, we, fv;
  logic [1:0][9:0]  addr;
  logic [1:0][15:0] d0, d1, ov;
  logic [1:0][7:0]  fc;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // write log captured from each RAM port, and the expected write list
  logic [41:0] wlog [2][LOGN];
  logic [41:0] elog [2][LOGN];
  int unsigned wn [2];
  int unsigned en [2];
  int unsigned em_fc [2];
  int unsigned em_ov [2];

  mic_capture_writer_if #(.DATA_W(16)) sif0 ();
  mic_capture_writer_if #(.DATA_W(16)) sif1 ();

  assign sif0.s_valid = v[0];
  assign sif0.s_ch0   = c0[0];
  assign sif0.s_ch1   = c1[0];
  assign rdy[0]       = sif0.s_ready;
  assign sif1.s_valid = v[1];
  assign sif1.s_ch0   = c0[1];
  assign sif1.s_ch1   = c1[1];
  assign rdy[1]       = sif1.s_ready;

  mic_capture_writer #(.DATA_W(16), .ADDR_W(10), .AUTO_REARM(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .s_if(sif0),
    .mem_we(we[0]), .mem_addr(addr[0]), .mem_din0(d0[0]), .mem_din1(d1[0]),
    .frame_valid(fv[0]), .frame_ack(ack[0]), .frame_cnt(fc[0]), .overrun_cnt(ov[0])
  );

  mic_capture_writer #(.DATA_W(16), .ADDR_W(10), .AUTO_REARM(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .s_if(sif1),
    .mem_we(we[1]), .mem_addr(addr[1]), .mem_din0(d0[1]), .mem_din1(d1[1]),
    .frame_valid(fv[1]), .frame_ack(ack[1]), .frame_cnt(fc[1]), .overrun_cnt(ov[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d] && wn[d] < LOGN) begin
        wlog[d][wn[d]] = {addr[d], d0[d], d1[d]};
        wn[d] = wn[d] + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned count_bad(input int d, input int unsigned wb,
                                            input int unsigned eb, input int unsigned n);
    int unsigned bad = 0;
    for (int unsigned i = 0; i < n; i++)
      if (wlog[d][wb+i] !== elog[d][eb+i]) bad++;
    return bad;
  endfunction

  // Presents `count` pairs to a DUT known to be in FILL; gaps and stray acks are random.
  task automatic drive_pairs(input int d, input int unsigned gap_pct, input bit ramp,
                             input int unsigned first, input int unsigned count,
                             input bit stray_ack);
    int unsigned k = 0;
    bit valid;
    logic [15:0] a, b;
    while (k < count) begin
      valid = ($urandom_range(99) >= gap_pct);
      a = ramp ? 16'(first + k) : 16'($urandom);
      b = ramp ? ~a : 16'($urandom);
      v[d]  = valid;
      c0[d] = a;
      c1[d] = b;
      ack[d] = stray_ack && ($urandom_range(9) == 0);
      tick();
      if (valid) begin
        elog[d][en[d]] = {10'(first + k), a, b};
        en[d] = en[d] + 1;
        k++;
      end
    end
    v[d]   = 1'b0;
    ack[d] = 1'b0;
  endtask

  task automatic test_reset;
    logic [68:0] o;
    rst_n = 1'b0;
    start = '0; ack = '0; v = '0; c0 = '0; c1 = '0;
    #3;
    for (int d = 0; d < 2; d++) begin
      o = {rdy[d], we[d], addr[d], d0[d], d1[d], fv[d], fc[d], ov[d]};
      total_cnt++;
      if (o !== 69'd0) $display("FAIL reset_outs dut%0d got=%h exp=0", d, o);
      else pass_cnt++;
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (rdy !== 2'b00) $display("FAIL idle_ready got=%b exp=00", rdy);
    else pass_cnt++;
  endtask

  task automatic test_fill_ramp;
    int unsigned wb, eb, bad;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    total_cnt++;
    if (rdy[0] !== 1'b1) $display("FAIL fill_ready got=%b exp=1", rdy[0]);
    else pass_cnt++;
    wb = wn[0]; eb = en[0];
    drive_pairs(0, 0, 1'b1, 0, 1024, 1'b0);
    total_cnt++;
    if ({we[0], addr[0], fv[0]} !== {1'b1, 10'd1023, 1'b0})
      $display("FAIL last_write got=%b/%0d/%b exp=1/1023/0", we[0], addr[0], fv[0]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({fv[0], we[0], rdy[0], fc[0]} !== {1'b1, 1'b0, OVR_EN, 8'(em_fc[0])})
      $display("FAIL frame_valid_rise got=%b/%b/%b/%0d exp=1/0/%b/%0d",
               fv[0], we[0], rdy[0], fc[0], OVR_EN, em_fc[0]);
    else pass_cnt++;
    bad = count_bad(0, wb, eb, 1024);
    total_cnt++;
    if (wn[0] - wb !== 1024 || bad !== 0)
      $display("FAIL ramp_writes got=%0d writes/%0d bad exp=1024/0", wn[0] - wb, bad);
    else pass_cnt++;
  endtask

  task automatic test_hold;
    int unsigned wb = wn[0];
    v[0] = 1'b1;
    repeat (50) begin
      c0[0] = 16'($urandom);
      tick();
    end
    v[0] = 1'b0;
    if (OVR_EN) em_ov[0] = (em_ov[0] + 50 > 16'hFFFF) ? 16'hFFFF : em_ov[0] + 50;
    tick();
    total_cnt++;
    if (wn[0] !== wb || rdy[0] !== OVR_EN || fv[0] !== 1'b1)
      $display("FAIL hold_frozen got=%0d writes rdy=%b fv=%b exp=0 writes rdy=%b fv=1",
               wn[0] - wb, rdy[0], fv[0], OVR_EN);
    else pass_cnt++;
    total_cnt++;
    if (ov[0] !== 16'(em_ov[0])) $display("FAIL overrun_cnt got=%0d exp=%0d", ov[0], em_ov[0]);
    else pass_cnt++;
  endtask

  task automatic test_ack_rearm;
    int unsigned wb, eb, bad;
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    em_fc[0]++;
    total_cnt++;
    if ({fv[0], fc[0], rdy[0]} !== {1'b0, 8'(em_fc[0]), 1'b1})
      $display("FAIL ack_rearm got=%b/%0d/%b exp=0/%0d/1", fv[0], fc[0], rdy[0], em_fc[0]);
    else pass_cnt++;
    wb = wn[0]; eb = en[0];
    drive_pairs(0, 0, 1'b0, 0, 1, 1'b0);
    total_cnt++;
    if (we[0] !== 1'b1 || addr[0] !== 10'd0)
      $display("FAIL rearm_first_addr got=%b/%0d exp=1/0", we[0], addr[0]);
    else pass_cnt++;
    test_random_gaps(wb, eb);
  endtask

  task automatic test_random_gaps(input int unsigned wb, input int unsigned eb);
    int unsigned bad;
    drive_pairs(0, 30, 1'b0, 1, 1023, 1'b1);
    total_cnt++;
    if ({we[0], addr[0], fv[0]} !== {1'b1, 10'd1023, 1'b0})
      $display("FAIL gap_last_write got=%b/%0d/%b exp=1/1023/0", we[0], addr[0], fv[0]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (fv[0] !== 1'b1 || fc[0] !== 8'(em_fc[0]))
      $display("FAIL stray_ack got=fv%b/cnt%0d exp=fv1/cnt%0d", fv[0], fc[0], em_fc[0]);
    else pass_cnt++;
    bad = count_bad(0, wb, eb, 1024);
    total_cnt++;
    if (wn[0] - wb !== 1024 || bad !== 0)
      $display("FAIL gap_writes got=%0d writes/%0d bad exp=1024/0", wn[0] - wb, bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe;
    logic [68:0] o;
    int unsigned wb, eb, bad;
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    em_fc[0]++;
    total_cnt++;
    if (fc[0] !== 8'(em_fc[0])) $display("FAIL second_ack_cnt got=%0d exp=%0d", fc[0], em_fc[0]);
    else pass_cnt++;
    drive_pairs(0, 0, 1'b0, 0, 500, 1'b0);
    rst_n = 1'b0;
    #1;
    o = {rdy[0], we[0], addr[0], d0[0], d1[0], fv[0], fc[0], ov[0]};
    total_cnt++;
    if (o !== 69'd0) $display("FAIL midframe_reset got=%h exp=0", o);
    else pass_cnt++;
    em_fc[0] = 0; em_fc[1] = 0; em_ov[0] = 0; em_ov[1] = 0;
    tick();
    rst_n = 1'b1;
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wb = wn[0]; eb = en[0];
    drive_pairs(0, 0, 1'b1, 0, 1024, 1'b0);
    tick();
    bad = count_bad(0, wb, eb, 1024);
    total_cnt++;
    if (wn[0] - wb !== 1024 || bad !== 0 || fv[0] !== 1'b1)
      $display("FAIL restart_writes got=%0d writes/%0d bad fv=%b exp=1024/0 fv=1",
               wn[0] - wb, bad, fv[0]);
    else pass_cnt++;
  endtask

  task automatic test_no_rearm;
    int unsigned wb, eb, bad;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    wb = wn[1]; eb = en[1];
    drive_pairs(1, 0, 1'b1, 0, 10, 1'b0);
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    drive_pairs(1, 20, 1'b0, 10, 1014, 1'b0);
    tick();
    bad = count_bad(1, wb, eb, 1024);
    total_cnt++;
    if (wn[1] - wb !== 1024 || bad !== 0 || fv[1] !== 1'b1)
      $display("FAIL start_in_fill got=%0d writes/%0d bad fv=%b exp=1024/0 fv=1",
               wn[1] - wb, bad, fv[1]);
    else pass_cnt++;
    start[1] = 1'b1;
    ack[1]   = 1'b1;
    tick();
    start[1] = 1'b0;
    ack[1]   = 1'b0;
    em_fc[1]++;
    total_cnt++;
    if ({fv[1], fc[1], rdy[1]} !== {1'b0, 8'(em_fc[1]), 1'b0})
      $display("FAIL ack_to_idle got=%b/%0d/%b exp=0/%0d/0", fv[1], fc[1], rdy[1], em_fc[1]);
    else pass_cnt++;
    wb = wn[1];
    v[1] = 1'b1;
    repeat (5) tick();
    v[1] = 1'b0;
    tick();
    total_cnt++;
    if (wn[1] !== wb || rdy[1] !== 1'b0)
      $display("FAIL idle_no_write got=%0d writes rdy=%b exp=0 writes rdy=0", wn[1] - wb, rdy[1]);
    else pass_cnt++;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    total_cnt++;
    if (rdy[1] !== 1'b1) $display("FAIL idle_rearm got=%b exp=1", rdy[1]);
    else pass_cnt++;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      wn[d] = 0; en[d] = 0; em_fc[d] = 0; em_ov[d] = 0;
    end
    test_reset();
    test_fill_ramp();
    test_hold();
    test_ack_rearm();
    test_reset_midframe();
    test_no_rearm();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
